// File: rtl/speed_display_driver_if.sv
// Speed-to-display bus: km/h value in, multiplexed 7-segment drive and busy out.
interface speed_display_driver_if;
  logic [6:0] kmh;
  logic [6:0] seg;
  logic [1:0] an;
  logic       busy;

  modport master (output kmh, input seg, an, busy);
  modport slave  (input kmh, output seg, an, busy);
endinterface

// File: rtl/speed_display_driver.sv
// Two-digit multiplexed 7-segment driver for the km/h value: sequential
// shift-add-3 BCD conversion, leading-zero blanking, overspeed blinking.
module speed_display_driver #(
  parameter int REFRESH_DIV    = 8,
  parameter int BLINK_DIV      = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int MAX_VAL        = 99
) (
  input logic                  clk,
  input logic                  reset,
  speed_display_driver_if.slave bus
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam bit ALOW = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_OFF = ALOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = ALOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e        state_q;
  logic [6:0]    bin_q, last_bin_q;
  logic [7:0]    bcd_q;
  logic [2:0]    bitcnt_q;
  logic [3:0]    disp_tens_q, disp_ones_q;
  logic          ovs_q;
  logic [RW-1:0] ref_cnt_q;
  logic          sel_q;       // 0 = ones slot, 1 = tens slot
  logic [BW-1:0] blink_cnt_q;
  logic          blink_off_q;
  logic [6:0]    seg_q;
  logic [1:0]    an_q;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [6:0]  val;
  logic [7:0]  bcd_adj;
  logic [14:0] shifted;
  assign val     = (bus.kmh > 7'(MAX_VAL)) ? 7'(MAX_VAL) : bus.kmh;
  assign bcd_adj = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  // Top bit of the adjusted BCD can never be set for a 7-bit input, so it drops off.
  assign shifted = {bcd_adj, bin_q} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      bitcnt_q    <= '0;
      last_bin_q  <= '0;
      disp_tens_q <= '0;
      disp_ones_q <= '0;
      ovs_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (val != last_bin_q) begin
          bin_q      <= val;
          bcd_q      <= '0;
          bitcnt_q   <= '0;
          last_bin_q <= val;
          state_q    <= CONV;
        end
        CONV: begin
          {bcd_q, bin_q} <= shifted;
          bitcnt_q       <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd6) state_q <= DONE;
        end
        DONE: begin
          disp_tens_q <= bcd_q[7:4];
          disp_ones_q <= bcd_q[3:0];
          // last_bin_q still holds the value just converted
          ovs_q       <= (last_bin_q == 7'(MAX_VAL));
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt_q   <= '0;
      sel_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
        ref_cnt_q <= '0;
        sel_q     <= ~sel_q;
      end else begin
        ref_cnt_q <= ref_cnt_q + 1'b1;
      end
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  logic       blank;
  logic [6:0] seg_hi, seg_d;
  logic [1:0] an_hi, an_d;
  assign blank  = (ovs_q && blink_off_q) || (sel_q && disp_tens_q == 4'd0);
  assign seg_hi = blank ? 7'h00 : seg_decode(sel_q ? disp_tens_q : disp_ones_q);
  assign an_hi  = sel_q ? 2'b10 : 2'b01;
  assign seg_d  = ALOW ? ~seg_hi : seg_hi;
  assign an_d   = ALOW ? ~an_hi : an_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.busy = (state_q != IDLE);
endmodule
